// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered digit data, hex decode,
// leading-zero suppression and PWM brightness on the digit enables.
module seg7_scan_ctrl #(
    parameter int NDIG       = 8,
    parameter int DIV_W      = 17,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [4*NDIG-1:0] digits,
    input  logic [NDIG-1:0]   dp_in,
    input  logic [NDIG-1:0]   blank_in,
    input  logic              lz_en,
    input  logic [3:0]        bright,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              pending,
    output logic              frame_done
);
    localparam int   IDX_W = $clog2(NDIG);
    localparam logic POL   = ACTIVE_LOW;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h7E;
            4'h1:    hex7 = 7'h30;
            4'h2:    hex7 = 7'h6D;
            4'h3:    hex7 = 7'h79;
            4'h4:    hex7 = 7'h33;
            4'h5:    hex7 = 7'h5B;
            4'h6:    hex7 = 7'h5F;
            4'h7:    hex7 = 7'h70;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h7B;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h1F;
            4'hC:    hex7 = 7'h4E;
            4'hD:    hex7 = 7'h3D;
            4'hE:    hex7 = 7'h4F;
            default: hex7 = 7'h47;
        endcase
    endfunction

    logic [DIV_W-1:0]  presc;
    logic [IDX_W-1:0]  idx;
    logic              tick;
    logic              wrap;

    logic [4*NDIG-1:0] pend_dig;
    logic [NDIG-1:0]   pend_dp;
    logic [NDIG-1:0]   pend_blank;
    logic [4*NDIG-1:0] disp_dig;
    logic [NDIG-1:0]   disp_dp;
    logic [NDIG-1:0]   disp_blank;

    logic [NDIG-1:0]   lz_mask;
    logic              lz_run;

    logic [3:0]        nib_p0;
    logic              blank_p0;
    logic              lit_p0;
    logic [NDIG-1:0]   an_p0;
    logic [6:0]        seg_p0;
    logic              dp_p0;
    logic [NDIG-1:0]   an_p1;
    logic [6:0]        seg_p1;
    logic              dp_p1;

    assign tick = &presc;
    assign wrap = tick && (idx == IDX_W'(NDIG - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            presc      <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            presc      <= presc + DIV_W'(1);
            frame_done <= wrap;
            if (tick) begin
                idx <= wrap ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // A load on the wrap cycle goes straight to the display; otherwise it waits in the pending buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_dig   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            disp_dig   <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
            pending    <= 1'b0;
        end else if (wrap) begin
            pending <= 1'b0;
            if (load) begin
                disp_dig   <= digits;
                disp_dp    <= dp_in;
                disp_blank <= blank_in;
            end else if (pending) begin
                disp_dig   <= pend_dig;
                disp_dp    <= pend_dp;
                disp_blank <= pend_blank;
            end
        end else if (load) begin
            pend_dig   <= digits;
            pend_dp    <= dp_in;
            pend_blank <= blank_in;
            pending    <= 1'b1;
        end
    end

    // lz_mask[i] is set when digit i and every digit above it are zero; digit 0 is never masked.
    always_comb begin
        lz_run  = 1'b1;
        lz_mask = '0;
        for (int i = NDIG - 1; i > 0; i--) begin
            lz_run     = lz_run && (disp_dig[4*i +: 4] == 4'd0);
            lz_mask[i] = lz_run;
        end
    end

    // Stage p0: combinational slot decode
    assign nib_p0   = disp_dig[{idx, 2'b00} +: 4];
    assign blank_p0 = disp_blank[idx] | (lz_en & lz_mask[idx]);
    assign lit_p0   = (bright == 4'hF) || (presc[DIV_W-1 -: 4] < bright);
    assign an_p0    = lit_p0 ? (NDIG'(1) << idx) : '0;
    assign seg_p0   = (lit_p0 && !blank_p0) ? hex7(nib_p0) : 7'd0;
    assign dp_p0    = lit_p0 && !blank_p0 && disp_dp[idx];

    // Stage p1: registered, polarity-adjusted pin drive
    always_ff @(posedge clk) begin
        if (reset) begin
            an_p1  <= {NDIG{POL}};
            seg_p1 <= {7{POL}};
            dp_p1  <= POL;
        end else begin
            an_p1  <= an_p0 ^ {NDIG{POL}};
            seg_p1 <= seg_p0 ^ {7{POL}};
            dp_p1  <= dp_p0 ^ POL;
        end
    end

    assign an  = an_p1;
    assign seg = seg_p1;
    assign dp  = dp_p1;

endmodule
